// File: rtl/life_engine.sv
// life_engine: registered Game of Life generation engine for a ROWS x COLS grid.
//
// Ports:
//   clk, reset  - single clock, synchronous active-high reset
//   load, seed  - load seed pattern (cell (r,c) = bit r*COLS+c), returns to IDLE
//   run, step   - free-run enable / single-generation pulse while idle
//   wrap        - 1 = toroidal edges, 0 = out-of-grid cells are dead
//   period      - in RUN, evolve once every period+1 cycles
//   grid        - current generation
//   gen_count   - generations since load/reset, saturating
//   running     - engine is in RUN
//   stable      - sticky, last evolution left the grid unchanged
//   extinct     - sticky, last evolution produced an empty grid
//   tick        - high in the cycle grid holds a freshly evolved generation

// One cell's next-state rule from its 8 neighbour bits.
module life_cell (
  input  logic       self_i,
  input  logic [7:0] nbr_i,
  output logic       next_o
);
  logic [3:0] cnt;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, nbr_i[i]};
  end

  assign next_o = (cnt == 4'd3) || (self_i && (cnt == 4'd2));
endmodule

module life_engine #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16,
  parameter int DIV_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] seed,
  input  logic                 run,
  input  logic                 step,
  input  logic                 wrap,
  input  logic [DIV_W-1:0]     period,
  output logic [ROWS*COLS-1:0] grid,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 running,
  output logic                 stable,
  output logic                 extinct,
  output logic                 tick
);
  localparam int N = ROWS * COLS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       grid_q, grid_d;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               stable_q, stable_d;
  logic               extinct_q, extinct_d;
  logic               tick_q, tick_d;

  logic [N-1:0]       next_grid;
  logic               evolve;

  // Neighbour wiring is resolved at elaboration: in-grid neighbours connect
  // directly, edge neighbours go through the wrap gate to the opposite side.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] nbr;
      for (genvar k = 0; k < 9; k++) begin : g_n
        if (k != 4) begin : g_use
          localparam int  RR  = r + k / 3 - 1;
          localparam int  CC  = c + k % 3 - 1;
          localparam bit  IN  = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
          localparam int  SRC = ((RR + ROWS) % ROWS) * COLS + ((CC + COLS) % COLS);
          localparam int  NI  = (k < 4) ? k : k - 1;
          assign nbr[NI] = (IN ? 1'b1 : wrap) & grid_q[SRC];
        end
      end
      life_cell u_cell (
        .self_i (grid_q[r*COLS+c]),
        .nbr_i  (nbr),
        .next_o (next_grid[r*COLS+c])
      );
    end
  end

  always_comb begin
    state_d   = state_q;
    grid_d    = grid_q;
    gen_d     = gen_q;
    div_d     = div_q;
    stable_d  = stable_q;
    extinct_d = extinct_q;
    tick_d    = 1'b0;
    evolve    = 1'b0;
    if (load) begin
      grid_d    = seed;
      gen_d     = '0;
      div_d     = '0;
      stable_d  = 1'b0;
      extinct_d = 1'b0;
      state_d   = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          evolve = step;
          if (run) begin
            state_d = S_RUN;
            div_d   = '0;
          end
        end
        S_RUN: begin
          if (!run) begin
            state_d = S_IDLE;
            div_d   = '0;
          end else if (div_q == period) begin
            evolve = 1'b1;
            div_d  = '0;
          end else begin
            div_d = div_q + 1'b1;  // wraps through 0 if period was lowered below it
          end
        end
        default: ;  // HALT: everything frozen until load/reset
      endcase
      if (evolve) begin
        grid_d = next_grid;
        tick_d = 1'b1;
        if (gen_q != {GEN_W{1'b1}}) gen_d = gen_q + 1'b1;
        if (next_grid == '0)    extinct_d = 1'b1;
        if (next_grid == grid_q) stable_d = 1'b1;
        // Halt overrides the RUN entry of a simultaneous step+run.
        if ((next_grid == '0) || (next_grid == grid_q)) state_d = S_HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grid_q    <= '0;
      gen_q     <= '0;
      div_q     <= '0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      gen_q     <= gen_d;
      div_q     <= div_d;
      stable_q  <= stable_d;
      extinct_q <= extinct_d;
      tick_q    <= tick_d;
    end
  end

  assign grid      = grid_q;
  assign gen_count = gen_q;
  assign running   = (state_q == S_RUN);
  assign stable    = stable_q;
  assign extinct   = extinct_q;
  assign tick      = tick_q;
endmodule

// File: tb/tb_life_engine.sv
module tb_life_engine;
  localparam int ROWS = 8, COLS = 8, GEN_W = 16, DIV_W = 8;
  localparam int N = ROWS * COLS;

  logic             clk = 1'b0;
  logic             reset = 1'b1, load = 1'b0, run = 1'b0, step = 1'b0, wrap = 1'b0;
  logic [N-1:0]     seed = '0;
  logic [DIV_W-1:0] period = '0;
  logic [N-1:0]     grid;
  logic [GEN_W-1:0] gen_count;
  logic             running, stable, extinct, tick;

  life_engine #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run), .step(step),
    .wrap(wrap), .period(period), .grid(grid), .gen_count(gen_count),
    .running(running), .stable(stable), .extinct(extinct), .tick(tick)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference generation rule on plain 2-D coordinates.
  function automatic logic [N-1:0] life_next(input logic [N-1:0] g, input bit w);
    logic [N-1:0] o = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        int n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr, cc = c + dc;
            if (dr == 0 && dc == 0) continue;
            if (w) begin rr = (rr + ROWS) % ROWS; cc = (cc + COLS) % COLS; end
            if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) n += int'(g[rr*COLS+cc]);
          end
        o[r*COLS+c] = (n == 3) || (g[r*COLS+c] && n == 2);
      end
    return o;
  endfunction

  // Behavioural model: mode 0 = idle, 1 = free-running, 2 = halted.
  int           m_mode = 0;
  logic [N-1:0] m_grid = '0;
  int           m_gen = 0;
  logic [7:0]   m_div = '0;
  bit           m_stab = 0, m_ext = 0, m_tick = 0;

  always @(posedge clk) begin : model
    bit ev;
    logic [N-1:0] nx;
    ev = 0;
    m_tick <= 1'b0;
    if (reset) begin
      m_mode <= 0; m_grid <= '0; m_gen <= 0; m_div <= '0; m_stab <= 0; m_ext <= 0;
    end else if (load) begin
      m_mode <= 0; m_grid <= seed; m_gen <= 0; m_div <= '0; m_stab <= 0; m_ext <= 0;
    end else begin
      if (m_mode == 0) begin
        ev = step;
        if (run) begin m_mode <= 1; m_div <= '0; end
      end else if (m_mode == 1) begin
        if (!run) begin m_mode <= 0; m_div <= '0; end
        else if (m_div == period) begin ev = 1; m_div <= '0; end
        else m_div <= m_div + 8'd1;
      end
      if (ev) begin
        nx = life_next(m_grid, wrap);
        m_grid <= nx;
        m_tick <= 1'b1;
        m_gen  <= (m_gen == 65535) ? m_gen : m_gen + 1;
        if (nx == '0) m_ext <= 1;
        if (nx == m_grid) m_stab <= 1;
        if (nx == '0 || nx == m_grid) m_mode <= 2;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("grid", 64'(grid), 64'(m_grid));
      chk("gen_count", 64'(gen_count), 64'(m_gen));
      chk("running", 64'(running), 64'(m_mode == 1));
      chk("stable", 64'(stable), 64'(m_stab));
      chk("extinct", 64'(extinct), 64'(m_ext));
      chk("tick", 64'(tick), 64'(m_tick));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [N-1:0] s);
    seed = s; load = 1'b1; run = 1'b0; step = 1'b0;
    cyc(); load = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1; cyc(); step = 1'b0;
  endtask

  function automatic logic [N-1:0] cells(input int idx[]);
    logic [N-1:0] v = '0;
    foreach (idx[i]) v[idx[i]] = 1'b1;
    return v;
  endfunction

  logic [N-1:0] blinker_h, blinker_v, block, lone, glider;
  int ticks, budget;

  initial begin
    blinker_h = cells('{26, 27, 28});
    blinker_v = cells('{19, 27, 35});
    block     = cells('{0, 1, 8, 9});
    lone      = cells('{36});
    glider    = cells('{1, 10, 16, 17, 18});

    cyc(); reset = 1'b0; chk_en = 1'b1;
    chk("reset_grid", 64'(grid), 64'd0);
    chk("reset_gen", 64'(gen_count), 64'd0);
    chk("reset_flags", {60'd0, running, stable, extinct, tick}, 64'd0);

    // Blinker single steps
    wrap = 1'b0;
    do_load(blinker_h);
    do_step();
    chk("blinker_s1", 64'(grid), 64'(blinker_v));
    chk("blinker_tick", 64'(tick), 64'd1);
    do_step();
    chk("blinker_s2", 64'(grid), 64'(blinker_h));
    chk("blinker_gen", 64'(gen_count), 64'd2);
    chk("blinker_stable", 64'(stable), 64'd0);

    // Block still-life halts, then ignores step/run
    do_load(block);
    do_step();
    chk("block_grid", 64'(grid), 64'(block));
    chk("block_flags", {62'd0, stable, extinct}, 64'd2);
    do_step();
    run = 1'b1; cyc(3); run = 1'b0;
    chk("block_frozen_gen", 64'(gen_count), 64'd1);
    chk("block_not_running", 64'(running), 64'd0);

    // Lone cell dies in free-run
    do_load(lone);
    period = '0; run = 1'b1; cyc();  // edge enters RUN
    cyc();                            // first evolution
    chk("lone_grid", 64'(grid), 64'd0);
    chk("lone_flags", {62'd0, stable, extinct}, 64'd1);
    chk("lone_gen", 64'(gen_count), 64'd1);
    cyc();
    chk("lone_running", 64'(running), 64'd0);
    run = 1'b0;

    // Glider on torus returns after 32 generations
    wrap = 1'b1;
    do_load(glider);
    run = 1'b1; cyc(33); run = 1'b0;
    chk("glider_wrap_grid", 64'(grid), 64'(glider));
    chk("glider_wrap_gen", 64'(gen_count), 64'd32);
    cyc();

    // Without wrap the glider settles into a block
    wrap = 1'b0;
    do_load(glider);
    run = 1'b1; cyc();
    budget = 0;
    while (running && budget < 200) begin cyc(); budget++; end
    run = 1'b0;
    chk("glider_nowrap_halt", {62'd0, running, stable}, 64'd1);

    // Divider: period 3 gives a tick every 4th cycle
    wrap = 1'b1;
    do_load(blinker_h);
    period = 8'd3; run = 1'b1; cyc();
    ticks = 0;
    for (int i = 0; i < 16; i++) begin cyc(); ticks += int'(tick); end
    chk("div_ticks", 64'(ticks), 64'd4);
    chk("div_gen", 64'(gen_count), 64'd4);
    cyc(2); run = 1'b0; cyc();
    chk("div_stop_running", 64'(running), 64'd0);
    cyc(6);
    chk("div_stop_gen", 64'(gen_count), 64'd4);

    // Load and reset mid-run
    do_load(blinker_h);
    period = '0; run = 1'b1; cyc(6);
    chk("midrun_gen5", 64'(gen_count), 64'd5);
    seed = block; load = 1'b1; cyc(); load = 1'b0; run = 1'b0;
    chk("midrun_load_grid", 64'(grid), 64'(block));
    chk("midrun_load_gen", 64'(gen_count), 64'd0);
    chk("midrun_load_flags", {60'd0, running, stable, extinct, tick}, 64'd0);
    do_load(blinker_h);
    run = 1'b1; cyc(4);
    reset = 1'b1; cyc(); reset = 1'b0; run = 1'b0;
    chk("midrun_reset", {grid == '0, gen_count == '0, running, stable, extinct, tick}, 64'h30);

    // Randomized phase, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      load  = ($urandom_range(0, 39) == 0);
      if (load) begin
        seed = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 0) seed = seed & {$urandom, $urandom};
        wrap = $urandom_range(0, 1);
      end
      if ($urandom_range(0, 9) == 0) run = ~run;
      step = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) period = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) wrap = ~wrap;
      cyc();
    end
    reset = 1'b0; load = 1'b0; run = 1'b0; step = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/life_engine.md
Name: life_engine

Overview:
Parametrised, fully registered Game of Life generation engine for a ROWS x COLS grid. It replaces the fixed 8x8 seed/evolve selector and takes over the next-generation logic internally. It adds single-step and free-run modes, a programmable generation period, selectable toroidal wrap, a saturating generation counter, and automatic halt on a stable or extinct grid. It sits between the seed/control source (switches or host) and the display/readout logic.

Parameters:
ROWS, 8, grid rows (>=3)
COLS, 8, grid columns (>=3)
GEN_W, 16, generation counter width
DIV_W, 8, period divider width

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
load  input  1  level; grid <= seed on the next edge
seed  input  ROWS*COLS  initial pattern; cell (r,c) = bit r*COLS+c
run  input  1  level; free-run enable
step  input  1  single-cycle pulse; advance one generation while idle
wrap  input  1  1 = toroidal edges, 0 = out-of-grid cells dead
period  input  DIV_W  in RUN, evolve once every period+1 cycles
grid  output  ROWS*COLS  current registered generation
gen_count  output  GEN_W  generations since last load/reset, saturating
running  output  1  state == RUN
stable  output  1  sticky; last evolution produced an unchanged grid
extinct  output  1  sticky; last evolution produced an all-zero grid
tick  output  1  one-cycle pulse, high in the cycle the grid register holds a newly evolved generation

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: grid=0, gen_count=0, divider=0, state=IDLE, running=0, stable=0, extinct=0, tick=0.
- States are IDLE, RUN and HALT. All outputs are registered or decoded directly from state.
- Priority on each edge, highest first: reset, then load, then the state actions below.
- load, in any state: grid<=seed, gen_count<=0, divider<=0, stable<=0, extinct<=0, tick<=0, state<=IDLE. run and step are ignored in that cycle.
- Evolution rule: next(r,c)=1 when neighbours==3, or when cell(r,c)=1 and neighbours==2; otherwise 0.
  - Count all 8 neighbours with a 4-bit count.
  - wrap=1: indices wrap modulo ROWS/COLS.
  - wrap=0: cells outside the grid count as 0.
  - wrap is sampled on the evolving edge.
- On every evolution edge:
  - grid<=next, tick<=1, gen_count<=gen_count+1, saturating at 2^GEN_W-1.
  - If next==0: extinct<=1.
  - If next==grid: stable<=1.
  - If either flag is set: state<=HALT. HALT takes precedence over any other transition.
- IDLE:
  - step=1: evolve.
  - run=1: state<=RUN, divider<=0.
  - step and run together: evolve and enter RUN, unless the halt condition applies.
- RUN:
  - run=0: state<=IDLE, divider<=0. No evolution on that edge.
  - Otherwise, if divider==period: evolve, divider<=0. Else divider<=divider+1.
  - step is ignored.
  - period=0 evolves every cycle.
  - A change to period mid-run takes effect at the next compare. If divider>period, divider counts up and wraps through 0.
- HALT: grid, gen_count and flags are frozen. run and step are ignored. Exit only via load or reset.
- Latency:
  - step edge -> new grid and tick=1 in the following cycle.
  - run asserted at edge N -> first evolution at edge N+1+period.
- Oscillators (period >= 2) do not halt. Only exact fixed points or extinction halt.

Test Plan:
- Blinker: load cells (3,2),(3,3),(3,4), then step x2. Required: grid after step 1 = bits (2,3),(3,3),(4,3); after step 2 = the original pattern; gen_count=2; stable=0; no HALT.
- Block still-life: load 2x2 at (0,0), pulse step. Required: grid unchanged, stable=1, extinct=0, running=0, state HALT, gen_count=1. A following step or run has no effect.
- Lone cell: load (4,4) only, set run=1 with period=0. Required: next cycle grid=0, extinct=1, stable=0, gen_count=1, halted, running drops to 0.
- Wrap: glider at the top-left corner with wrap=1 and period=0, run 32 cycles on 8x8. Required: grid equals the original seed and gen_count=32. With wrap=0, the pattern decays into a block and HALTs with stable=1.
- Divider: run=1 with period=3 on a blinker for 16 cycles. Required: tick pulses exactly every 4th cycle (4 pulses) and gen_count=4. run=0 mid-count stops evolution and running=0 on the next edge.
- Load/reset mid-run: during RUN with gen_count=5, assert load. Required: next cycle grid=seed, gen_count=0, flags=0, state IDLE. Synchronous reset mid-run clears all outputs to 0 on the next edge.
